// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel/window containers and the
// window sequencer's state encoding.
package cnn_pkg;

    localparam int PIX_W = 16;

    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef pixel_t [3:0] window_t;

    typedef enum logic [2:0] {
        FILL,
        ISSUE,
        WAIT_FIN,
        WAIT_REL,
        EMIT
    } state_t;

endpackage

// File: rtl/pool_window_sequencer.sv
// Buffers one MxM feature map, then walks it in stride-2 2x2 windows,
// handshaking each with the pooling core and streaming the results.
module pool_window_sequencer
    import cnn_pkg::*;
#(
    parameter int M = 6,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_pixel,
    output logic                in_ready,
    output logic                win_start,
    output logic [4*W-1:0]      win_pixels,
    input  logic                win_finish,
    input  logic signed [W-1:0] win_result,
    output logic                out_valid,
    output logic signed [W-1:0] out_pixel,
    output logic                out_last,
    input  logic                out_ready
);

    localparam int N  = M * M;
    localparam int H  = M / 2;
    localparam int CW = $clog2(N);
    localparam int HW = (H > 1) ? $clog2(H) : 1;

    generate
        if (M < 2 || (M % 2) != 0) begin : g_bad_m
            $error("pool_window_sequencer: M must be even and >= 2");
        end
    endgenerate

    state_t state, state_n;

    logic signed [W-1:0] mem [N];
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] base;
    logic [HW-1:0] wr, wc;
    logic          accept;
    logic          last_pix;
    logic          last_win;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign last_pix = (pix_cnt == CW'(N - 1));
    assign last_win = (wr == HW'(H - 1)) && (wc == HW'(H - 1));
    // top-left pixel of window (wr, wc) in the row-major buffer
    assign base = CW'(2 * M * int'(wr) + 2 * int'(wc));

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[pix_cnt] <= in_pixel;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            FILL:     if (accept && last_pix) state_n = ISSUE;
            ISSUE:    state_n = WAIT_FIN;
            WAIT_FIN: if (win_finish) state_n = WAIT_REL;
            WAIT_REL: if (!win_finish) state_n = EMIT;
            EMIT:     if (out_ready) state_n = last_win ? FILL : ISSUE;
            default:  state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            pix_cnt    <= '0;
            wr         <= '0;
            wc         <= '0;
            win_start  <= 1'b0;
            win_pixels <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_last   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                FILL: begin
                    if (accept) begin
                        pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
                        if (last_pix) begin
                            wr <= '0;
                            wc <= '0;
                        end
                    end
                end
                ISSUE: begin
                    win_pixels <= {mem[base],
                                   mem[base + CW'(1)],
                                   mem[base + CW'(M)],
                                   mem[base + CW'(M + 1)]};
                    win_start  <= 1'b1;
                end
                WAIT_FIN: begin
                    if (win_finish) begin
                        out_pixel <= win_result;
                        win_start <= 1'b0;
                    end
                end
                WAIT_REL: begin
                    if (!win_finish) begin
                        out_valid <= 1'b1;
                        out_last  <= last_win;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!last_win) begin
                            if (wc == HW'(H - 1)) begin
                                wc <= '0;
                                wr <= wr + HW'(1);
                            end else begin
                                wc <= wc + HW'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
